dbg_run_ctrl: RTL and testbench

Run controller for the MIPS datapath under UART debug control. It decodes command bytes from the UART receiver, gates the pipeline with a per-cycle clock enable, and supports these modes:
- single step
- N-step
- run-to-halt
- run-to-breakpoint on PC

After every run or step it hands off to the snapshot dumper with a request/done handshake. It sits between the UART RX and the datapath/dumper, replacing free-running clock toggling with a cycle-exact enable.

---
 rtl/dbg_run_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_dbg_run_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl
// ------------
// Run controller that sits between the UART receiver and the MIPS datapath.
// Command bytes from the UART select single step, N-step, free run (to HALT
// or to a PC breakpoint) and datapath reset.  The datapath advances only on
// cycles where dp_clk_en is high.  Every step/run ends with a snapshot dump
// requested from the dumper.
//
// Handshakes: rx_rdy and dump_done are one-cycle strobes sampled on posedge
// clk; dump_req is a level that stays high from DUMP entry up to and
// including the cycle in which dump_done is seen (it drops on that edge).
//
// Ports
//   clk        system clock, all logic on posedge
//   reset_n    asynchronous active-low reset
//   rx_rdy     strobe: rx_bus holds a new byte
//   rx_bus     received byte
//   dp_pc      datapath PC (IF stage)
//   dp_halt    datapath retired HALT (level until dp_reset)
//   dump_done  strobe: dumper finished the snapshot
//   dp_clk_en  datapath advances one cycle on each clk where high
//   dp_reset   synchronous reset to the datapath (registered)
//   dump_req   level request to the dumper
//   bp_valid   breakpoint armed (registered)
//   busy       state is neither IDLE nor HALTED (registered)
//   dbg_state  current FSM state, for debug/checkers
//
// Command bytes: 'p' step 1, 'n'+N step N, 'c' run, 'b'+4 bytes (MSB first)
// set breakpoint, 'x' clear breakpoint, 'r' datapath reset.

module dbg_run_ctrl #(
  parameter int PC_W      = 32,  // datapath PC / breakpoint width (<= 32)
  parameter int RESET_CYC = 4    // dp_reset length for 'r' (>= 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx_rdy,
  input  logic [7:0]      rx_bus,
  input  logic [PC_W-1:0] dp_pc,
  input  logic            dp_halt,
  input  logic            dump_done,
  output logic            dp_clk_en,
  output logic            dp_reset,
  output logic            dump_req,
  output logic            bp_valid,
  output logic            busy,
  output logic [2:0]      dbg_state
);

  localparam logic [7:0] CMD_STEP1 = 8'h70;  // 'p'
  localparam logic [7:0] CMD_STEPN = 8'h6E;  // 'n'
  localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
  localparam logic [7:0] CMD_BP    = 8'h62;  // 'b'
  localparam logic [7:0] CMD_CLRBP = 8'h78;  // 'x'
  localparam logic [7:0] CMD_RST   = 8'h72;  // 'r'

  localparam int RC_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARG    = 3'd1,
    S_STEP   = 3'd2,
    S_RUN    = 3'd3,
    S_RST    = 3'd4,
    S_DUMP   = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        cnt;        // remaining step count
  logic [PC_W-1:0]   bp_addr;
  logic [23:0]       arg_shift;  // first three breakpoint bytes
  logic [1:0]        byte_idx;   // breakpoint bytes received so far
  logic              arg_is_bp;  // ARG collects 'b' (1) or 'n' (0) argument
  logic              first;      // high only on the first RUN cycle
  logic [RC_W-1:0]   rst_cnt;    // dp_reset cycles left after the current one
  logic              run_stop;
  logic [31:0]       bp_word;

  // Fourth breakpoint byte arrives on rx_bus; assemble the full word here.
  assign bp_word   = {arg_shift, rx_bus};

  // The breakpoint compare is masked on the first RUN cycle so that 'c'
  // can leave a PC that already sits on the breakpoint.
  assign run_stop  = dp_halt | (bp_valid & (dp_pc == bp_addr) & ~first);

  assign dbg_state = state;

  // Next state and Moore/combinational outputs.
  always_comb begin
    state_next = state;
    dp_clk_en  = 1'b0;
    dump_req   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_rdy) begin
          case (rx_bus)
            CMD_STEP1:        state_next = S_STEP;
            CMD_STEPN, CMD_BP: state_next = S_ARG;
            CMD_RUN:          state_next = S_RUN;
            CMD_RST:          state_next = S_RST;
            default:          state_next = S_IDLE;
          endcase
        end
      end
      S_ARG: begin
        if (rx_rdy) begin
          if (arg_is_bp) begin
            if (byte_idx == 2'd3) state_next = S_IDLE;
          end else begin
            state_next = (rx_bus == 8'd0) ? S_DUMP : S_STEP;
          end
        end
      end
      S_STEP: begin
        // A halted datapath must not see another enable.
        if (dp_halt) begin
          state_next = S_DUMP;
        end else begin
          dp_clk_en = 1'b1;
          if (cnt <= 8'd1) state_next = S_DUMP;
        end
      end
      S_RUN: begin
        dp_clk_en = ~run_stop;
        if (run_stop) state_next = S_DUMP;
      end
      S_DUMP: begin
        dump_req = 1'b1;
        if (dump_done) state_next = dp_halt ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (rx_rdy && (rx_bus == CMD_RST)) state_next = S_RST;
      end
      S_RST: begin
        if (rst_cnt == '0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      dp_reset  <= 1'b0;
      bp_valid  <= 1'b0;
      bp_addr   <= '0;
      cnt       <= 8'd0;
      arg_shift <= 24'd0;
      byte_idx  <= 2'd0;
      arg_is_bp <= 1'b0;
      first     <= 1'b0;
      rst_cnt   <= '0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != S_IDLE) && (state_next != S_HALTED);
      dp_reset <= (state_next == S_RST);
      first    <= (state_next == S_RUN) && (state != S_RUN);

      if ((state_next == S_RST) && (state != S_RST)) begin
        rst_cnt <= RC_W'(RESET_CYC - 1);
      end else if ((state == S_RST) && (rst_cnt != '0)) begin
        rst_cnt <= rst_cnt - RC_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (rx_rdy) begin
            case (rx_bus)
              CMD_STEP1: cnt <= 8'd1;
              CMD_STEPN: begin
                arg_is_bp <= 1'b0;
                byte_idx  <= 2'd0;
              end
              CMD_BP: begin
                arg_is_bp <= 1'b1;
                byte_idx  <= 2'd0;
              end
              CMD_CLRBP: bp_valid <= 1'b0;
              default: ;
            endcase
          end
        end
        S_ARG: begin
          if (rx_rdy) begin
            if (arg_is_bp) begin
              arg_shift <= {arg_shift[15:0], rx_bus};
              byte_idx  <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                bp_addr  <= bp_word[PC_W-1:0];
                bp_valid <= 1'b1;
              end
            end else begin
              cnt <= rx_bus;
            end
          end
        end
        S_STEP: begin
          // Saturating decrement: the counter never wraps below zero.
          if (dp_clk_en && (cnt != 8'd0)) cnt <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Testbench for dbg_run_ctrl: directed scenarios plus a random command
// stream, checked against a transaction-level reference model through an
// expected-response queue.

module tb_dbg_run_ctrl;

  localparam int PC_W      = 32;
  localparam int RESET_CYC = 4;
  localparam int SB_W      = 56;   // {kind[3:0], bursts[7:0], enables[11:0], pc[31:0]}

  localparam logic [7:0] C_P = 8'h70;
  localparam logic [7:0] C_N = 8'h6E;
  localparam logic [7:0] C_C = 8'h63;
  localparam logic [7:0] C_B = 8'h62;
  localparam logic [7:0] C_X = 8'h78;
  localparam logic [7:0] C_R = 8'h72;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DUMP   = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  logic            clk;
  logic            reset_n;
  logic            rx_rdy;
  logic [7:0]      rx_bus;
  logic [PC_W-1:0] dp_pc;
  logic            dp_halt;
  logic            dump_done;
  logic            dp_clk_en;
  logic            dp_reset;
  logic            dump_req;
  logic            bp_valid;
  logic            busy;
  logic [2:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [SB_W-1:0] exp_q[$];

  // Reference model state (what the system should look like between commands)
  logic [31:0] halt_pc;
  logic [31:0] m_pc;
  logic [31:0] m_bp;
  logic        m_bpv;
  logic        m_halted;

  int   dump_delay;
  logic hold_dump;

  // Monitor state
  int   mon_en;
  int   mon_bursts;
  int   mon_rcnt;
  logic prev_en;
  logic prev_req;
  logic prev_rst;

  // Random loop scratch
  logic [7:0]  r_cmd;
  logic [31:0] r_arg;
  int          r_sel;
  int          r_start;
  logic [7:0]  junk_tab [4];

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dbg_run_ctrl #(.PC_W(PC_W), .RESET_CYC(RESET_CYC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_rdy    (rx_rdy),
    .rx_bus    (rx_bus),
    .dp_pc     (dp_pc),
    .dp_halt   (dp_halt),
    .dump_done (dump_done),
    .dp_clk_en (dp_clk_en),
    .dp_reset  (dp_reset),
    .dump_req  (dump_req),
    .bp_valid  (bp_valid),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Datapath stand-in: PC advances by 4 per enabled cycle, HALT latches when
  // the PC reaches halt_pc and clears on dp_reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_pc   <= '0;
      dp_halt <= 1'b0;
    end else if (dp_reset) begin
      dp_pc   <= '0;
      dp_halt <= 1'b0;
    end else if (dp_clk_en) begin
      dp_pc <= dp_pc + 32'd4;
      if (dp_pc + 32'd4 == halt_pc) dp_halt <= 1'b1;
    end
  end

  // Dumper stand-in: answers dump_req with a dump_done strobe after
  // dump_delay cycles (0 = same cycle dump_req rises).
  initial begin
    dump_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && dump_req && !hold_dump) begin
        repeat (dump_delay) @(negedge clk);
        dump_done = 1'b1;
        @(posedge clk);
        #1 dump_done = 1'b0;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  function automatic logic [SB_W-1:0] mk_rec(input logic [3:0] kind, input int bursts,
                                             input int en, input logic [31:0] pc);
    return {kind, 8'(bursts), 12'(en), pc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_pop(input string name, input logic [SB_W-1:0] act);
    logic [SB_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected response 0x%0h, expected none at %0t", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(act), 64'(e));
    end
  endtask

  // Monitor: counts enable cycles/bursts and dp_reset cycles, and emits one
  // record when a dump starts and one when a datapath reset ends.
  initial begin
    mon_en = 0; mon_bursts = 0; mon_rcnt = 0;
    prev_en = 1'b0; prev_req = 1'b0; prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_en = 0; mon_bursts = 0; mon_rcnt = 0;
        prev_en = 1'b0; prev_req = 1'b0; prev_rst = 1'b0;
      end else begin
        checks++;
        if (dp_clk_en && dp_reset) begin
          errors++;
          $display("FAIL en_rst_overlap: dp_clk_en=1 dp_reset=1, expected never both at %0t", $time);
        end
        if (dp_clk_en) begin
          mon_en++;
          if (!prev_en) mon_bursts++;
        end
        if (dp_reset) mon_rcnt++;
        if (dump_req && !prev_req) begin
          compare_pop("dump", mk_rec(4'd0, mon_bursts, mon_en, dp_pc));
          mon_en = 0; mon_bursts = 0;
        end
        if (!dp_reset && prev_rst) begin
          compare_pop("reset", mk_rec(4'd1, mon_rcnt, mon_en, dp_pc));
          mon_rcnt = 0; mon_en = 0; mon_bursts = 0;
        end
        prev_en  = dp_clk_en;
        prev_req = dump_req;
        prev_rst = dp_reset;
      end
    end
  end

  // ---------------- reference model ----------------
  // Computes the response to one complete command from the rules: steps are
  // limited by the distance to HALT, a run stops at HALT or at the first
  // later PC equal to the breakpoint.
  task automatic model_push(input logic [7:0] c, input logic [31:0] arg, output int starts);
    int          en;
    logic [31:0] sth;
    logic [31:0] diff;
    logic        exec;
    starts = 0;
    exec   = 1'b0;
    en     = 0;
    if (m_halted) begin
      if (c == C_R) begin
        exp_q.push_back(mk_rec(4'd1, RESET_CYC, 0, 32'd0));
        m_pc     = 32'd0;
        m_halted = 1'b0;
      end
    end else begin
      sth = (halt_pc - m_pc) >> 2;
      case (c)
        C_P, C_N: begin
          en   = (c == C_P) ? 1 : int'(arg[7:0]);
          if (en > int'(sth)) en = int'(sth);
          exec = 1'b1;
        end
        C_C: begin
          en   = int'(sth);
          diff = m_bp - m_pc;
          if (m_bpv && (m_bp > m_pc) && (diff[1:0] == 2'b00) && (int'(diff >> 2) < en))
            en = int'(diff >> 2);
          exec = 1'b1;
        end
        C_B: begin
          m_bp  = arg;
          m_bpv = 1'b1;
        end
        C_X: m_bpv = 1'b0;
        C_R: begin
          exp_q.push_back(mk_rec(4'd1, RESET_CYC, 0, 32'd0));
          m_pc = 32'd0;
        end
        default: ;
      endcase
      if (exec) begin
        exp_q.push_back(mk_rec(4'd0, (en > 0) ? 1 : 0, en, m_pc + 32'(4 * en)));
        m_pc     = m_pc + 32'(4 * en);
        m_halted = (m_pc == halt_pc);
        starts   = (en > 0) ? 1 : 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    rx_bus = b;
    rx_rdy = 1'b1;
    @(posedge clk);
    #1 rx_rdy = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] c, input logic [31:0] arg);
    int starts;
    model_push(c, arg, starts);
    dump_delay = $urandom_range(0, 3);
    send_byte(c);
    if (c == C_N) send_byte(arg[7:0]);
    if (c == C_B) begin
      send_byte(arg[31:24]);
      send_byte(arg[23:16]);
      send_byte(arg[15:8]);
      send_byte(arg[7:0]);
    end
    // The cycle right after the accepting edge must already be enabled.
    if (starts != 0) check("first_enable", 64'(dp_clk_en), 64'd1);
  endtask

  task automatic settle();
    int t;
    t = 0;
    while ((busy || dump_req) && (t < 400)) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL settle_timeout: busy=%0d dump_req=%0d, expected both 0 within 400 cycles", busy, dump_req);
    end
    @(negedge clk);
    check("state", 64'(dbg_state), m_halted ? 64'(ST_HALTED) : 64'(ST_IDLE));
    check("bp_valid", 64'(bp_valid), 64'(m_bpv));
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    junk_tab[0] = 8'h41; junk_tab[1] = 8'h00; junk_tab[2] = 8'hFF; junk_tab[3] = 8'h71;
    reset_n    = 1'b1;
    rx_rdy     = 1'b0;
    rx_bus     = 8'h00;
    hold_dump  = 1'b0;
    dump_delay = 0;
    halt_pc    = 32'd40;
    m_pc = 32'd0; m_bp = 32'd0; m_bpv = 1'b0; m_halted = 1'b0;

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dp_clk_en", 64'(dp_clk_en), 64'd0);
    check("rst_dp_reset",  64'(dp_reset),  64'd0);
    check("rst_dump_req",  64'(dump_req),  64'd0);
    check("rst_bp_valid",  64'(bp_valid),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;

    // Directed: step, N-step, N=0, reset, breakpoint run, halt run.
    do_cmd(C_P, 32'd0);            settle();
    do_cmd(C_N, 32'd5);            settle();
    do_cmd(C_N, 32'd0);            settle();
    do_cmd(C_R, 32'd0);            settle();
    do_cmd(C_B, 32'h0000_0020);    settle();
    do_cmd(C_C, 32'd0);            settle();   // stops at 0x20
    do_cmd(C_C, 32'd0);            settle();   // leaves 0x20, halts at 0x28
    do_cmd(C_P, 32'd0);            settle();   // ignored in HALTED
    do_cmd(C_R, 32'd0);            settle();
    do_cmd(C_X, 32'd0);            settle();
    do_cmd(C_C, 32'd0);            settle();   // 10 enables then HALT
    do_cmd(C_R, 32'd0);            settle();

    // Bytes arriving while a dump is pending are dropped.
    hold_dump = 1'b1;
    do_cmd(C_P, 32'd0);
    begin
      int t;
      t = 0;
      while (!dump_req && (t < 20)) begin
        @(negedge clk);
        t++;
      end
      check("dump_pending", 64'(dump_req), 64'd1);
    end
    send_byte(C_P);
    send_byte(8'h41);
    check("dump_hold_state", 64'(dbg_state), 64'(ST_DUMP));
    check("dump_hold_en",    64'(dp_clk_en), 64'd0);
    hold_dump = 1'b0;
    settle();
    do_cmd(8'h41, 32'd0);          settle();   // unknown byte in IDLE

    // Asynchronous reset while running.
    halt_pc = 32'd400;
    do_cmd(C_B, 32'h0000_0200);    settle();
    send_byte(C_C);
    repeat (3) @(posedge clk);
    #3;
    check("run_before_reset", 64'(dp_clk_en), 64'd1);
    reset_n = 1'b0;
    #1;
    check("arst_dp_clk_en", 64'(dp_clk_en), 64'd0);
    check("arst_dump_req",  64'(dump_req),  64'd0);
    check("arst_dp_reset",  64'(dp_reset),  64'd0);
    check("arst_bp_valid",  64'(bp_valid),  64'd0);
    check("arst_state",     64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_pc = 32'd0; m_bpv = 1'b0; m_halted = 1'b0;
    halt_pc = 32'd80;
    settle();

    // Random command stream.
    for (int i = 0; i < 60; i++) begin
      r_sel = $urandom_range(0, 99);
      r_arg = 32'd0;
      if (m_halted) begin
        if (r_sel < 40) r_cmd = C_R;
        else begin
          case (r_sel % 5)
            0: r_cmd = C_P;
            1: r_cmd = C_C;
            2: r_cmd = C_X;
            3: r_cmd = 8'h41;
            default: begin
              r_cmd = C_N;
              r_arg = 32'($urandom_range(0, 12));
            end
          endcase
        end
      end else begin
        if (r_sel < 8) r_cmd = C_R;
        else if (r_sel < 25) r_cmd = C_P;
        else if (r_sel < 45) begin
          r_cmd = C_N;
          r_arg = 32'($urandom_range(0, 12));
        end else if (r_sel < 65) r_cmd = C_C;
        else if (r_sel < 82) begin
          r_cmd   = C_B;
          r_start = $urandom_range(0, 9);
          if (r_start == 0)      r_arg = $urandom();
          else if (r_start == 1) r_arg = 32'(4 * $urandom_range(0, 40) + 1);
          else                   r_arg = 32'(4 * $urandom_range(0, 40));
        end else if (r_sel < 90) r_cmd = C_X;
        else r_cmd = junk_tab[$urandom_range(0, 3)];
      end
      do_cmd(r_cmd, r_arg);
      settle();
      if (r_cmd == C_R) halt_pc = 32'(4 * $urandom_range(6, 30));
    end

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
